id_stage: RTL and testbench

Instruction-decode stage of the 5-stage RV32I pipeline, directly downstream of the fetch stage. It takes the fetched `pc`/`instruction` pair, decodes RV32I fields, immediates and control signals, and reads the 32x32 register file, which has a writeback port with same-cycle bypass. It registers everything into the ID/EX pipeline register, with stall and flush control.

---
 rtl/id_stage_if.sv | 52 +++++
 rtl/id_stage.sv | 197 +++++++++++++++++++
 tb/tb_id_stage.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_if.sv
// Fetch->decode->execute bundle for the ID stage.
//   master: fetch side, writeback port, hazard control; consumes the ID/EX register.
//   slave : the ID stage itself.
// Inputs to the stage:
//   pc_in, instr_in, valid_in             fetched instruction
//   stall, flush                          hazard control
//   wb_en, wb_rd, wb_data                 register-file writeback
// Outputs of the stage:
//   ID/EX register (pc_out, operands, imm, indices, fields, control, valid_out, illegal)
interface id_stage_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc_in;
  logic [31:0]     instr_in;
  logic            valid_in;
  logic            stall;
  logic            flush;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [6:0]      opcode;
  logic            reg_write;
  logic            mem_read;
  logic            mem_write;
  logic            alu_src;
  logic            branch;
  logic            jump;
  logic            valid_out;
  logic            illegal;

  modport master (
    output pc_in, instr_in, valid_in, stall, flush, wb_en, wb_rd, wb_data,
    input  pc_out, rs1_data, rs2_data, imm, rd, rs1, rs2, funct3, funct7, opcode,
           reg_write, mem_read, mem_write, alu_src, branch, jump, valid_out, illegal
  );

  modport slave (
    input  pc_in, instr_in, valid_in, stall, flush, wb_en, wb_rd, wb_data,
    output pc_out, rs1_data, rs2_data, imm, rd, rs1, rs2, funct3, funct7, opcode,
           reg_write, mem_read, mem_write, alu_src, branch, jump, valid_out, illegal
  );
endinterface

// File: rtl/id_stage.sv
// RV32I instruction-decode stage.
// Decodes fields, immediates and control from the fetched instruction, reads the
// 32x32 register file (with write-through bypass from the writeback port) and
// registers the result into the ID/EX pipeline register.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset (clears ID/EX register and register file)
//   bus    id_stage_if slave modport (fetch inputs, writeback, stall/flush, ID/EX outputs)
// Only XLEN = 32 is supported.
module id_stage #(
  parameter int          XLEN = 32,
  parameter logic [31:0] NOP  = 32'h0000_0013
) (
  input  logic       clk,
  input  logic       reset,
  id_stage_if.slave  bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [6:0]      opcode;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            alu_src;
    logic            branch;
    logic            jump;
    logic            valid;
    logic            illegal;
  } idex_t;

  // Field/immediate/control decode of one instruction. valid is left 0; the
  // caller decides whether the result is a real instruction.
  function automatic idex_t decode(input logic [31:0] ins,
                                   input logic [XLEN-1:0] d1,
                                   input logic [XLEN-1:0] d2,
                                   input logic [XLEN-1:0] pc);
    idex_t r;
    r          = '0;
    r.pc       = pc;
    r.rs1_data = d1;
    r.rs2_data = d2;
    r.rd       = ins[11:7];
    r.rs1      = ins[19:15];
    r.rs2      = ins[24:20];
    r.funct3   = ins[14:12];
    r.funct7   = ins[31:25];
    r.opcode   = ins[6:0];
    case (ins[6:0])
      OPC_OP: begin
        r.reg_write = 1'b1;
      end
      OPC_OP_IMM: begin
        r.reg_write = 1'b1;
        r.alu_src   = 1'b1;
        r.imm       = {{20{ins[31]}}, ins[31:20]};
      end
      OPC_LOAD: begin
        r.reg_write = 1'b1;
        r.alu_src   = 1'b1;
        r.mem_read  = 1'b1;
        r.imm       = {{20{ins[31]}}, ins[31:20]};
      end
      OPC_STORE: begin
        r.alu_src   = 1'b1;
        r.mem_write = 1'b1;
        r.imm       = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      OPC_BRANCH: begin
        r.branch = 1'b1;
        r.imm    = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      OPC_JAL: begin
        r.reg_write = 1'b1;
        r.jump      = 1'b1;
        r.imm       = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      OPC_JALR: begin
        r.reg_write = 1'b1;
        r.alu_src   = 1'b1;
        r.jump      = 1'b1;
        r.imm       = {{20{ins[31]}}, ins[31:20]};
      end
      OPC_LUI, OPC_AUIPC: begin
        r.reg_write = 1'b1;
        r.alu_src   = 1'b1;
        r.imm       = {ins[31:12], 12'b0};
      end
      default: begin
        // unknown opcode: no side effects downstream, immediate left at 0
        r.illegal = 1'b1;
      end
    endcase
    return r;
  endfunction

  // Register file. Entry 0 is never written after reset; reads of x0 are
  // forced to zero in the read path anyway.
  logic [XLEN-1:0] regs [32];
  logic            wb_hit_ok;

  assign wb_hit_ok = bus.wb_en && (bus.wb_rd != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_hit_ok) begin
      regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  logic [4:0]      rs1_idx, rs2_idx;
  logic [XLEN-1:0] rs1_val, rs2_val;
  idex_t           fetch_dec;
  idex_t           bubble;

  assign rs1_idx = bus.instr_in[19:15];
  assign rs2_idx = bus.instr_in[24:20];

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    // write-through: a writeback in this cycle is seen by this cycle's read
    if (rs1_idx != 5'd0) rs1_val = (wb_hit_ok && bus.wb_rd == rs1_idx) ? bus.wb_data : regs[rs1_idx];
    if (rs2_idx != 5'd0) rs2_val = (wb_hit_ok && bus.wb_rd == rs2_idx) ? bus.wb_data : regs[rs2_idx];
  end

  always_comb begin
    fetch_dec       = decode(bus.instr_in, rs1_val, rs2_val, bus.pc_in);
    fetch_dec.valid = 1'b1;

    // Bubble carries the NOP fields but no control, so nothing downstream acts on it.
    bubble           = decode(NOP, '0, '0, '0);
    bubble.reg_write = 1'b0;
    bubble.mem_read  = 1'b0;
    bubble.mem_write = 1'b0;
    bubble.alu_src   = 1'b0;
    bubble.branch    = 1'b0;
    bubble.jump      = 1'b0;
    bubble.valid     = 1'b0;
    bubble.illegal   = 1'b0;
  end

  idex_t q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (bus.flush) begin
      q <= bubble;
    end else if (bus.stall) begin
      q <= q;
    end else if (!bus.valid_in) begin
      q <= bubble;
    end else begin
      q <= fetch_dec;
    end
  end

  assign bus.pc_out    = q.pc;
  assign bus.rs1_data  = q.rs1_data;
  assign bus.rs2_data  = q.rs2_data;
  assign bus.imm       = q.imm;
  assign bus.rd        = q.rd;
  assign bus.rs1       = q.rs1;
  assign bus.rs2       = q.rs2;
  assign bus.funct3    = q.funct3;
  assign bus.funct7    = q.funct7;
  assign bus.opcode    = q.opcode;
  assign bus.reg_write = q.reg_write;
  assign bus.mem_read  = q.mem_read;
  assign bus.mem_write = q.mem_write;
  assign bus.alu_src   = q.alu_src;
  assign bus.branch    = q.branch;
  assign bus.jump      = q.jump;
  assign bus.valid_out = q.valid;
  assign bus.illegal   = q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed table, hand-written corner
// sequences, then randomized traffic against a behavioural reference model.
module tb_id_stage;

  logic clk;
  logic reset;

  id_stage_if #(.XLEN(32)) bus ();

  id_stage #(.XLEN(32), .NOP(32'h0000_0013)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7, op;
    logic        rw, mr, mw, as, br, jp, v, ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic        imm_chk;
    logic [4:0]  rd, rs1, rs2;
    logic [6:0]  ctrl; // {rw, mr, mw, as, br, jp, ill}
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] rf [32];
  exp_t        mq;

  function automatic exp_t zero_q();
    exp_t z;
    z = '{default: '0};
    return z;
  endfunction

  function automatic exp_t bubble_q();
    exp_t z;
    z = '{default: '0};
    z.op = 7'h13;
    return z;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (bus.wb_en && bus.wb_rd == idx) return bus.wb_data;
    return rf[idx];
  endfunction

  // Reference decode, written from the ISA field definitions with arithmetic.
  function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic [31:0] sgn;
    e = '{default: '0};
    sgn = ins[31] ? 32'hFFFF_FFFF : 32'h0;
    e.pc = pc;
    e.op = ins[6:0];
    e.rd = 5'((ins >> 7) & 32'h1f);
    e.f3 = 3'((ins >> 12) & 32'h7);
    e.rs1 = 5'((ins >> 15) & 32'h1f);
    e.rs2 = 5'((ins >> 20) & 32'h1f);
    e.f7 = 7'(ins >> 25);
    e.rs1d = model_read(e.rs1);
    e.rs2d = model_read(e.rs2);
    e.v = 1'b1;
    case (e.op)
      7'h33: begin e.rw = 1; end
      7'h13: begin e.rw = 1; e.as = 1; e.imm = 32'($signed(ins) >>> 20); end
      7'h03: begin e.rw = 1; e.as = 1; e.mr = 1; e.imm = 32'($signed(ins) >>> 20); end
      7'h23: begin e.as = 1; e.mw = 1;
        e.imm = (32'($signed(ins) >>> 25) << 5) | ((ins >> 7) & 32'h1f); end
      7'h63: begin e.br = 1;
        e.imm = (sgn & 32'hFFFF_F000) | (((ins >> 7) & 32'h1) << 11)
              | (((ins >> 25) & 32'h3f) << 5) | (((ins >> 8) & 32'hf) << 1); end
      7'h6F: begin e.rw = 1; e.jp = 1;
        e.imm = (sgn & 32'hFFF0_0000) | (((ins >> 12) & 32'hff) << 12)
              | (((ins >> 20) & 32'h1) << 11) | (((ins >> 21) & 32'h3ff) << 1); end
      7'h67: begin e.rw = 1; e.as = 1; e.jp = 1; e.imm = 32'($signed(ins) >>> 20); end
      7'h37, 7'h17: begin e.rw = 1; e.as = 1; e.imm = ins & 32'hFFFF_F000; end
      default: begin e.ill = 1; end
    endcase
    return e;
  endfunction

  function automatic void cmp(input string tag, input string fld,
                              input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s.%s actual=%08h required=%08h at %0t", tag, fld, act, exp, $time);
    end
  endfunction

  // Compare the whole ID/EX register against the model; pc is don't-care in bubbles.
  function automatic void check_model(input string tag, input bit full);
    if (full || mq.v) cmp(tag, "pc_out", bus.pc_out, mq.pc);
    cmp(tag, "rs1_data", bus.rs1_data, mq.rs1d);
    cmp(tag, "rs2_data", bus.rs2_data, mq.rs2d);
    cmp(tag, "imm", bus.imm, mq.imm);
    cmp(tag, "idx", {17'h0, bus.rd, bus.rs1, bus.rs2}, {17'h0, mq.rd, mq.rs1, mq.rs2});
    cmp(tag, "fields", {15'h0, bus.funct3, bus.funct7, bus.opcode}, {15'h0, mq.f3, mq.f7, mq.op});
    cmp(tag, "ctrl",
        {24'h0, bus.reg_write, bus.mem_read, bus.mem_write, bus.alu_src, bus.branch, bus.jump,
         bus.valid_out, bus.illegal},
        {24'h0, mq.rw, mq.mr, mq.mw, mq.as, mq.br, mq.jp, mq.v, mq.ill});
  endfunction

  // One clock: predict from current inputs, clock, update model, check.
  task automatic cycle(input string tag);
    exp_t n;
    if (bus.flush) n = bubble_q();
    else if (bus.stall) n = mq;
    else if (!bus.valid_in) n = bubble_q();
    else n = model_decode(bus.instr_in, bus.pc_in);
    @(posedge clk);
    if (bus.wb_en && bus.wb_rd != 0) rf[bus.wb_rd] = bus.wb_data;
    mq = n;
    #1;
    check_model(tag, 1'b0);
  endtask

  task automatic drive(input logic [31:0] ins, input logic vld, input logic stl, input logic fl);
    bus.instr_in = ins;
    bus.valid_in = vld;
    bus.stall    = stl;
    bus.flush    = fl;
    bus.pc_in    = bus.pc_in + 32'd4;
  endtask

  task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
    bus.wb_en = en;
    bus.wb_rd = r;
    bus.wb_data = d;
  endtask

  vec_t tbl [10];

  initial begin
    tbl[0] = '{32'h0050_0093, 32'h0000_0005, 1, 5'd1,  5'd0,  5'd5,  7'b1001000}; // addi x1,x0,5
    tbl[1] = '{32'h0020_A423, 32'h0000_0008, 1, 5'd8,  5'd1,  5'd2,  7'b0011000}; // sw x2,8(x1)
    tbl[2] = '{32'hFE00_0EE3, 32'hFFFF_FFFC, 1, 5'd29, 5'd0,  5'd0,  7'b0000100}; // beq x0,x0,-4
    tbl[3] = '{32'h1234_50B7, 32'h1234_5000, 1, 5'd1,  5'd8,  5'd3,  7'b1001000}; // lui
    tbl[4] = '{32'h0080_00EF, 32'h0000_0008, 1, 5'd1,  5'd0,  5'd8,  7'b1000010}; // jal x1,8
    tbl[5] = '{32'hFFC0_8067, 32'hFFFF_FFFC, 1, 5'd0,  5'd1,  5'd28, 7'b1001010}; // jalr x0,-4(x1)
    tbl[6] = '{32'h0000_1517, 32'h0000_1000, 1, 5'd10, 5'd0,  5'd0,  7'b1001000}; // auipc x10,1
    tbl[7] = '{32'h0040_A183, 32'h0000_0004, 1, 5'd3,  5'd1,  5'd4,  7'b1101000}; // lw x3,4(x1)
    tbl[8] = '{32'h0020_8133, 32'h0000_0000, 1, 5'd2,  5'd1,  5'd2,  7'b1000000}; // add x2,x1,x2
    tbl[9] = '{32'hFFFF_FFFF, 32'h0000_0000, 0, 5'd31, 5'd31, 5'd31, 7'b0000001}; // illegal

    reset = 1'b0;
    bus.pc_in = 32'h0000_00FC;
    bus.instr_in = 32'h0; bus.valid_in = 0; bus.stall = 0; bus.flush = 0;
    wb(0, 0, 0);
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    mq = zero_q();
    #12;
    check_model("reset", 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].instr, 1, 0, 0);
      wb(1, 5'd1, 32'h1000 + 32'(i));
      cycle("tbl");
      if (tbl[i].imm_chk) cmp("tbl_imm", "imm", bus.imm, tbl[i].imm);
      cmp("tbl_idx", "idx", {17'h0, bus.rd, bus.rs1, bus.rs2},
          {17'h0, tbl[i].rd, tbl[i].rs1, tbl[i].rs2});
      cmp("tbl_ctrl", "ctrl",
          {24'h0, bus.reg_write, bus.mem_read, bus.mem_write, bus.alu_src, bus.branch, bus.jump,
           bus.illegal, bus.valid_out},
          {24'h0, tbl[i].ctrl, 1'b1});
    end
    wb(0, 0, 0);

    // Bypass: write x3 in the same cycle as reading it
    drive(32'h0001_8233, 1, 0, 0);
    wb(1, 5'd3, 32'hDEAD_BEEF);
    cycle("bypass");
    cmp("bypass_rs1", "rs1_data", bus.rs1_data, 32'hDEAD_BEEF);

    // x0 write ignored
    drive(32'h0000_0233, 1, 0, 0);
    wb(1, 5'd0, 32'h0000_1234);
    cycle("x0_wr");
    drive(32'h0000_0233, 1, 0, 0);
    wb(0, 0, 0);
    cycle("x0_rd");
    cmp("x0_read", "rs1_data", bus.rs1_data, 32'h0);

    // Stall holds for 3 cycles while instr_in changes
    drive(32'h0050_0093, 1, 0, 0);
    cycle("stall_load");
    for (int k = 0; k < 3; k++) begin
      drive(32'h0020_A423 + 32'(k << 7), 1, 1, 0);
      wb(1, 5'd7, 32'h77 + 32'(k));
      cycle("stall_hold");
      cmp("stall_imm", "imm", bus.imm, 32'h5);
      cmp("stall_ctl", "rd/rw/as/v", {24'h0, bus.rd, bus.reg_write, bus.alu_src, bus.valid_out},
          {24'h0, 5'd1, 3'b111});
    end
    wb(0, 0, 0);

    // Stall and flush together: flush wins
    drive(32'h0050_0093, 1, 1, 1);
    cycle("stall_flush");
    cmp("flush_wins", "valid_out/reg_write", {30'h0, bus.valid_out, bus.reg_write}, 32'h0);

    // valid_in low gives bubble
    drive(32'h0050_0093, 0, 0, 0);
    cycle("valid_low");
    cmp("valid_low", "valid_out", {31'h0, bus.valid_out}, 32'h0);

    // Reset mid-stall: x1 written, valid instruction held, then async reset
    drive(32'h0050_0093, 1, 0, 0);
    wb(1, 5'd1, 32'h0000_0055);
    cycle("pre_rst");
    wb(0, 0, 0);
    drive(32'h0050_0093, 1, 1, 0);
    cycle("pre_rst_stall");
    #2;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    mq = zero_q();
    check_model("rst_mid_stall", 1'b1);
    cmp("rst_opcode", "opcode", {25'h0, bus.opcode}, 32'h0);
    #1;
    reset = 1'b1;
    drive(32'h0000_8133, 1, 0, 0); // add x2,x1,x0
    cycle("post_rst");
    cmp("rst_x1", "rs1_data", bus.rs1_data, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] ins;
      logic [6:0]  opc;
      int sel;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0: opc = 7'h33; 1: opc = 7'h13; 2: opc = 7'h03; 3: opc = 7'h23; 4: opc = 7'h63;
        5: opc = 7'h6F; 6: opc = 7'h67; 7: opc = 7'h37; 8: opc = 7'h17;
        default: opc = 7'($urandom);
      endcase
      ins = {$urandom} & 32'hFFFF_FF80;
      ins = ins | {25'h0, opc};
      drive(ins, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 1) == 1)
        wb(1, ($urandom_range(0, 2) == 0) ? ins[19:15] : 5'($urandom), $urandom);
      else
        wb(0, 5'($urandom), $urandom);
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
